// File: rtl/data_mem_ctrl_pkg.sv
// Shared constants, FSM encoding and lane helpers for the MEM-stage data memory controller.
package mem_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // funct3[1:0] encodes the access size for every legal load/store.
  function automatic logic [BE_W-1:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_replicate(input logic [2:0] f3, input logic [XLEN-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction
endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a bus read word and sign/zero-extends it.
module load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] bus_rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] result
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = bus_rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   result = {24'b0, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_HU:   result = {16'b0, half_lane};
      default: result = bus_rdata;
    endcase
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage load/store responder: one single-beat req/ready bus transaction per request,
// with misalign/illegal detection, request timeout and pipeline stall generation.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            rdata_valid,
  output logic            misalign,
  output logic            err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [BE_W-1:0] bus_be,
  input  logic            bus_ready,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t          state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             is_load_q;
  logic             fail_q;
  logic [XLEN-1:0]  rdata_q;
  logic [XLEN-1:0]  ext_data;
  logic             any_req, illegal, misaligned, start;

  load_extend u_load_extend (
    .bus_rdata (bus_rdata),
    .funct3    (f3_q),
    .offset    (off_q),
    .result    (ext_data)
  );

  always_comb begin
    any_req    = mem_read | mem_write;
    illegal    = (mem_read & mem_write)
               | (mem_read & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
               | (mem_write & (funct3 >= 3'b011));
    misaligned = ((funct3[1:0] == 2'b01) & addr[0])
               | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    start      = (state == IDLE) & any_req & ~illegal & ~misaligned;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = REQ;
      REQ:     if (bus_ready || (cnt == CNT_LAST)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request-side pulses are combinational; gating with rst_n keeps every output low in reset.
  always_comb begin
    stall       = rst_n & (start | (state == REQ));
    misalign    = rst_n & (state == IDLE) & any_req & ~illegal & misaligned;
    err         = rst_n & (((state == IDLE) & any_req & illegal) | ((state == DONE) & fail_q));
    rdata_valid = (state == DONE) & is_load_q & ~fail_q;
    rdata       = rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      is_load_q <= 1'b0;
      fail_q    <= 1'b0;
      rdata_q   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            is_load_q <= mem_read;
            fail_q    <= 1'b0;
            cnt       <= '0;
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[XLEN-1:2], 2'b00};
            bus_be    <= byte_enables(funct3, addr[1:0]);
            bus_wdata <= lane_replicate(funct3, wdata);
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (bus_ready) begin
            bus_req <= 1'b0;
            fail_q  <= bus_err;
            rdata_q <= (is_load_q && !bus_err) ? ext_data : '0;
          end else if (cnt == CNT_LAST) begin
            bus_req <= 1'b0;
            fail_q  <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
